// File: rtl/alu_seq.sv
// Sequential RV32 ALU with a valid/ready handshake and iterative one-bit-per-cycle shifter.
// Define ALU_SEQ_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_seq #(
    parameter int REG_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                alu_ctrl,
    input  logic [REG_DATA_WIDTH-1:0] a,
    input  logic [REG_DATA_WIDTH-1:0] b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REG_DATA_WIDTH-1:0] result,
    output logic                      zero
);
    localparam int W = REG_DATA_WIDTH;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [4:0]     cnt_q, cnt_d;
    logic           left_q, left_d;
    logic           arith_q, arith_d;

    logic [4:0]     sh;
    logic           is_shift;
    logic           go_shift;
    logic [W-1:0]   sll_res, srl_res, sra_res;
    logic [W-1:0]   alu_res;
    logic [W-1:0]   step;

    assign sh       = b[4:0];
    assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) ||
                      (alu_ctrl == OP_SRA);

`ifdef ALU_SEQ_FAST_SHIFT_EN
    assign sll_res  = a << sh;
    assign srl_res  = a >> sh;
    assign sra_res  = $signed(a) >>> sh;
    assign go_shift = 1'b0;
`else
    // Only a zero-distance shift completes in one cycle here, yielding a.
    assign sll_res  = a;
    assign srl_res  = a;
    assign sra_res  = a;
    assign go_shift = is_shift && (sh != 5'd0);
`endif

    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SLL:  alu_res = sll_res;
            OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(W-1){1'b0}}, (a < b)};
            OP_XOR:  alu_res = a ^ b;
            OP_SRL:  alu_res = srl_res;
            OP_SRA:  alu_res = sra_res;
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        step = acc_q >> 1;
        if (left_q) begin
            step = acc_q << 1;
        end else if (arith_q) begin
            step = {acc_q[W-1], acc_q[W-1:1]};
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = go_shift ? SHIFT : DONE;
            SHIFT:   if (cnt_q == 5'd1) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        arith_d = arith_q;
        if ((state_q == IDLE) && in_valid) begin
            acc_d   = go_shift ? a : alu_res;
            cnt_d   = go_shift ? sh : 5'd0;
            left_d  = (alu_ctrl == OP_SLL);
            arith_d = (alu_ctrl == OP_SRA);
        end else if (state_q == SHIFT) begin
            acc_d = step;
            cnt_d = cnt_q - 5'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            cnt_q   <= 5'd0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            arith_q <= arith_d;
        end
    end

    assign result = acc_q;
    assign zero   = (acc_q == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed cases, backpressure, reset abort, random ops.
// Honours ALU_SEQ_FAST_SHIFT_EN for expected latencies.
module tb_alu_seq;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    alu_seq #(.REG_DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   nchk = 0;
    int   nerr = 0;
    int   cyc  = 0;
    bit   prev_v = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(logic [3:0] op, logic [31:0] x,
                                          logic [31:0] y);
        int s;
        s = int'(y[4:0]);
        case (op)
            4'b0000: return x + y;
            4'b1000: return x - y;
            4'b0001: return x << s;
            4'b0010: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b0011: return (x < y) ? 32'd1 : 32'd0;
            4'b0100: return x ^ y;
            4'b0101: return x >> s;
            4'b1101: return 32'($signed(x) >>> s);
            4'b0110: return x | y;
            4'b0111: return x & y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int lat_of(logic [3:0] op, logic [31:0] y);
`ifdef ALU_SEQ_FAST_SHIFT_EN
        return 1;
`else
        if ((op == 4'b0001 || op == 4'b0101 || op == 4'b1101) && y[4:0] != 0)
            return int'(y[4:0]) + 1;
        return 1;
`endif
    endfunction

    // Monitor: compare every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    if (!prev_v)
                        chk("latency", cyc - q[0].acc, q[0].lat);
                    chk("result", result, q[0].res);
                    chk("zero", {31'd0, zero}, {31'd0, q[0].res == 32'd0});
                    chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
                    if (out_ready) void'(q.pop_front());
                end
            end
            prev_v = out_valid;
        end
    end

    task automatic issue(logic [3:0] op, logic [31:0] x, logic [31:0] y,
                         logic [31:0] exp_res);
        int n;
        exp_t e;
        @(posedge clk);
        #1;
        alu_ctrl = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) break;
        end
        if (n > 300) begin
            chk("accept_timeout", 32'd1, 32'd0);
        end else begin
            e.res = exp_res;
            e.lat = lat_of(op, y);
            e.acc = cyc;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        alu_ctrl = 4'($urandom);
    endtask

    task automatic drain(bit rnd);
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            if (rnd && n < 20) out_ready = 1'($urandom);
            else out_ready = 1'b1;
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        logic [31:0] x, y;
        logic [3:0]  op;
        int          n;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_ctrl  = 4'd0;
        a         = 32'd0;
        b         = 32'd0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Known-answer cases
        issue(4'b0000, 32'd5, 32'd7, 32'd12);
        drain(0);
        chk("add_in_ready_t2", {31'd0, in_ready}, 32'd1);
        issue(4'b1000, 32'd3, 32'd5, 32'hFFFF_FFFE);
        drain(0);
        issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1);
        drain(0);
        issue(4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0);
        drain(0);
        issue(4'b0100, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd0);
        drain(0);
        issue(4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000);
        drain(0);
        issue(4'b0001, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678);
        drain(0);
        issue(4'b0101, 32'h8000_0001, 32'd31, 32'd1);
        drain(0);
        issue(4'b1001, 32'hDEAD_BEEF, 32'd3, 32'd0);
        drain(0);

        // Backpressure in DONE with ignored request pulses
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(4'b0110, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", {31'd0, out_valid}, 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            alu_ctrl = 4'b0000;
            a        = $urandom;
            b        = $urandom;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_queue_empty", 32'(q.size()), 32'd0);

        // Reset aborts an in-flight long shift
        x = $urandom;
        issue(4'b0101, x, 32'd31, x >> 31);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_zero", {31'd0, zero}, 32'd1);
        q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (40) @(posedge clk);
        issue(4'b0000, 32'hFFFF_FFFF, 32'd2, 32'd1);
        drain(0);

        // Randomized operations with random backpressure
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom);
            x  = $urandom;
            y  = $urandom;
            if (i % 4 == 0) y[4:0] = 5'($urandom_range(0, 2));
            issue(op, x, y, model(op, x, y));
            drain(1);
        end
        drain(0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: REG_DATA_WIDTH, 32, operand/result width; shift amount is always operand b[4:0].
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 alu_ctrl  input  4  operation code = {funct7[5], funct3}, as produced by ALU_CONTROLLER.
REQ-007 a  input  REG_DATA_WIDTH  operand rs1.
REQ-008 b  input  REG_DATA_WIDTH  operand rs2/immediate.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  REG_DATA_WIDTH  registered operation result.
REQ-012 zero  output  1  high when result == 0.

Function
REQ-013 Encodings SHALL be: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT (signed), 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND; any other code yields result 0 with non-shift latency.
REQ-014 State machine SHALL have states IDLE, SHIFT, DONE.
REQ-015 in_ready SHALL be high only in IDLE; no acceptance in SHIFT or DONE.
REQ-016 Accept: in_valid && in_ready at a rising edge; a, b, alu_ctrl captured at that edge; inputs ignored afterwards.
REQ-017 Non-shift op, or shift with b[4:0] == 0: IDLE -> DONE, result registered at acceptance edge; out_valid high the cycle after acceptance (latency 1).
REQ-018 Shift (SLL/SRL/SRA) with k = b[4:0] >= 1: IDLE -> SHIFT, counter loaded with k; each SHIFT cycle shifts accumulator by one bit and decrements counter; the edge at which counter == 1 moves to DONE; out_valid first high k+1 cycles after acceptance.
REQ-019 SRA SHALL replicate bit REG_DATA_WIDTH-1 on every step; SLL/SRL fill with 0.
REQ-020 ADD/SUB wrap modulo 2^REG_DATA_WIDTH; SLT/SLTU results are 0 or 1, zero-extended.
REQ-021 DONE: out_valid high, result and zero held stable until out_valid && out_ready at an edge, then DONE -> IDLE; out_ready ignored outside DONE.
REQ-022 No result bypass: a new request is accepted no earlier than the cycle after the result handshake.
REQ-023 zero SHALL be derived combinationally from the result register.

Reset
REQ-024 On reset assertion, immediately: state IDLE, in_ready 1, out_valid 0, result 0, zero 1, counter 0.
REQ-025 Reset during SHIFT or DONE SHALL discard the in-flight operation; no out_valid pulse follows.

Configuration
REQ-026 Macro ALU_SEQ_FAST_SHIFT_EN: when defined, shifts use a single-cycle barrel shifter, all operations have latency 1, SHIFT state is never entered.
REQ-027 Without ALU_SEQ_FAST_SHIFT_EN: iterative shifting per REQ-018; all other behaviour identical in both builds.

Verification
REQ-028 ADD a=5, b=7 accepted cycle t, out_ready=1 -> out_valid cycle t+1, result 12, zero 0, in_ready 1 at t+2.
REQ-029 SUB a=3, b=5 -> result 0xFFFFFFFE; SLT a=0xFFFFFFFF, b=1 -> 1; SLTU same operands -> 0; XOR a=b=0xA5A5A5A5 -> 0, zero 1.
REQ-030 SRA a=0x80000000, b=4 accepted cycle t -> out_valid first at t+5, result 0xF8000000 (fast build: t+1); SLL b=0 -> latency 1, result = a.
REQ-031 Backpressure: hold out_ready=0 three cycles in DONE -> out_valid, result stable, in_ready 0, in_valid pulses ignored; raise out_ready -> IDLE next cycle.
REQ-032 Assert reset mid SRL with b=31 -> out_valid 0, result 0, in_ready 1 immediately; no stale result after reset release; next ADD completes normally.
